key_source_fsm: RTL and testbench
=================================

Name: key_source_fsm

Overview:
- Parametrised key generator feeding the RC4 decrypt core(s). Manual mode: debounced DE1 switch key, zero-extended to KEY_WIDTH. Sweep mode: steps keys KEY_START..KEY_END by KEY_STEP.
- Ready/valid handshake to the consumer. Latches the key the consumer reports as correct.
- Drives LEDs with key status. KEY_START/KEY_STEP allow several instances to partition the keyspace across parallel cores.

Parameters:
- KEY_WIDTH, 24: secret key width.
- SW_WIDTH, 10: switch input width; must satisfy SW_WIDTH <= KEY_WIDTH.
- LED_WIDTH, 10: LED output width; must satisfy LED_WIDTH <= KEY_WIDTH.
- DEBOUNCE_CYCLES, 4: consecutive stable samples needed before a manual key update; >= 1.
- KEY_START, 0: first sweep key.
- KEY_STEP, 1: sweep increment; >= 1.
- KEY_END, 2**KEY_WIDTH-1: last permitted sweep key; must satisfy KEY_START <= KEY_END.

Ports:
- CLOCK_50 in 1: sole clock; all logic on posedge.
- reset in 1: synchronous, active-high.
- mode in 1: 0 = manual, 1 = sweep.
- SW in SW_WIDTH: switch positions.
- key_ready in 1: consumer accepts the presented key.
- found in 1: consumer reports that the last accepted key decrypts correctly.
- LEDR out LED_WIDTH: status display.
- secret_key out KEY_WIDTH: presented key.
- key_available out 1: secret_key valid (handshake valid).
- key_changed out 1: one-cycle pulse, first cycle of a new secret_key value.
- key_found out 1: sticky; a match was reported.
- found_key out KEY_WIDTH: key captured at the match.
- sweep_done out 1: sticky; sweep range exhausted.

Behaviour:
- Interface: one clock (CLOCK_50); reset is synchronous and active-high.
- Reset (any state, mid-handshake included): state=IDLE. All outputs 0, debounce counter 0, internal last_accepted 0.
- States: IDLE, UPDATE, OUTPUT, SETTLE, ADVANCE, DONE, FOUND.
- Output decode per state:
  - UPDATE: key_changed=1, key_available=0.
  - OUTPUT: key_available=1.
  - All other states: key_changed=0, key_available=0.
- IDLE -> UPDATE, next cycle.
  - mode=0: the entry edge loads secret_key <= zero-extended SW. No debounce on this first load.
  - mode=1: the entry edge loads secret_key <= KEY_START.
  - Clears key_found, sweep_done, found_key.
- UPDATE -> OUTPUT, always. Latency from IDLE to key_available=1 is 2 cycles.
- Manual OUTPUT:
  - SW == secret_key[SW_WIDTH-1:0]: stay; counter cleared.
  - Otherwise: sample SW, counter=1, go to SETTLE.
- SETTLE:
  - SW equals the sample: counter++. On reaching DEBOUNCE_CYCLES, go to UPDATE and load the sample.
  - SW differs from the sample: resample, counter=1.
  - SW returns to secret_key: go back to OUTPUT with no pulse.
- Manual handshake: key_ready is ignored; found is honoured (see found rule).
- Sweep OUTPUT: stay until key_ready=1. On the accept cycle, last_accepted <= secret_key, then go to ADVANCE.
- ADVANCE: compute next = secret_key + KEY_STEP in KEY_WIDTH+1 bits.
  - next > KEY_END or carry out: go to DONE, set sweep_done=1, hold secret_key.
  - Otherwise: go to UPDATE, load next.
  - Accept-to-next-valid latency is 3 cycles.
- found rule (mode=1 any state except IDLE; mode=0 in OUTPUT):
  - Go to FOUND, set found_key <= last_accepted (mode=1) or secret_key (mode=0), set key_found=1.
  - found beats key_ready in the same cycle; that key is not accepted.
  - found in DONE still goes to FOUND; sweep_done stays 1.
- FOUND and DONE: terminal until reset or mode change. key_available=0.
- Mode change: if mode differs from its value registered on the previous cycle, go to IDLE next cycle, aborting any pending handshake.
- LEDR:
  - FOUND: found_key[LED_WIDTH-1:0].
  - DONE: all ones.
  - Otherwise: secret_key[LED_WIDTH-1:0].

Test Plan:
- Reset, mode=0, SW=10'h2A5 -> cycle 1 UPDATE (key_changed=1, secret_key=24'h0002A5), cycle 2 key_available=1, LEDR=10'h2A5.
- Manual debounce, DEBOUNCE_CYCLES=4: SW toggles 2A5->2A6 for 2 cycles, then back -> no key_changed, secret_key unchanged. SW held at 2A6 for 4 cycles -> one key_changed pulse, secret_key=24'h0002A6.
- Sweep, KEY_START=0, KEY_STEP=2, KEY_END=6, key_ready always 1 -> keys 0,2,4,6 each with one key_changed pulse. Then sweep_done=1, key_available=0, LEDR=10'h3FF.
- Sweep, key_ready held 0 for 10 cycles on key 4 -> secret_key stays 4, key_available stays 1, no advance. Raising key_ready -> next key 6.
- Sweep: accept key 2, then found=1 together with key_ready while key 4 is presented -> key_found=1, found_key=2, key 4 not accepted, LEDR=10'h002.
- Reset asserted mid-SETTLE, and mode toggled mid-sweep -> all outputs 0 the next cycle; with mode toggled, re-enters UPDATE from IDLE in the new mode.

Source files
------------

// File: rtl/key_source_if.sv
// key_source_if: ready/valid key handshake between the key source and a decrypt consumer
interface key_source_if #(parameter int KEY_WIDTH = 24);
  logic [KEY_WIDTH-1:0] secret_key;
  logic key_available, key_changed, key_ready, found;
  modport master (output secret_key, key_available, key_changed, input key_ready, found);
  modport slave (input secret_key, key_available, key_changed, output key_ready, found);
endinterface

// File: rtl/key_source_fsm.sv
// key_source_fsm: debounced manual or partitioned sweep RC4 key source with match capture
module key_source_fsm #(
  parameter int KEY_WIDTH = 24,
  parameter int SW_WIDTH = 10,
  parameter int LED_WIDTH = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter longint unsigned KEY_START = 0,
  parameter longint unsigned KEY_STEP = 1,
  parameter longint unsigned KEY_END = (64'd1 << KEY_WIDTH) - 64'd1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SW_WIDTH-1:0]  SW,
  key_source_if.master         ks,
  output logic [LED_WIDTH-1:0] LEDR,
  output logic                 key_found,
  output logic [KEY_WIDTH-1:0] found_key,
  output logic                 sweep_done
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_W = CW'(DEBOUNCE_CYCLES);
  localparam logic [KEY_WIDTH-1:0] START_W = KEY_WIDTH'(KEY_START);
  localparam logic [KEY_WIDTH:0] STEP_W = (KEY_WIDTH + 1)'(KEY_STEP);
  localparam logic [KEY_WIDTH:0] END_W = (KEY_WIDTH + 1)'(KEY_END);
  typedef enum logic [2:0] {IDLE, UPDATE, OUTPUT, SETTLE, ADVANCE, DONE, FOUND} state_t;
  state_t state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d, last_q, last_d, fkey_q, fkey_d;
  logic [SW_WIDTH-1:0] sample_q, sample_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic kfound_q, kfound_d, sdone_q, sdone_d, chg_q, chg_d, avail_q, avail_d, mode_prev_q;
  logic [KEY_WIDTH:0] next_w;
  logic sw_is_key;
  always_comb begin
    state_d = state_q;
    key_d = key_q;
    last_d = last_q;
    fkey_d = fkey_q;
    sample_d = sample_q;
    cnt_d = cnt_q;
    kfound_d = kfound_q;
    sdone_d = sdone_q;
    next_w = {1'b0, key_q} + STEP_W;
    sw_is_key = SW == key_q[SW_WIDTH-1:0];
    // a mode flip aborts everything and restarts from a cleared IDLE
    if (mode != mode_prev_q) begin
      state_d = IDLE;
      key_d = '0;
      last_d = '0;
      fkey_d = '0;
      sample_d = '0;
      cnt_d = '0;
      kfound_d = 1'b0;
      sdone_d = 1'b0;
    end else if (ks.found && state_q != IDLE && state_q != FOUND && (mode || state_q == OUTPUT)) begin
      state_d = FOUND;
      fkey_d = mode ? last_q : key_q;
      kfound_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = UPDATE;
          key_d = mode ? START_W : KEY_WIDTH'(SW);
          fkey_d = '0;
          kfound_d = 1'b0;
          sdone_d = 1'b0;
          cnt_d = '0;
        end
        UPDATE: begin
          state_d = OUTPUT;
          cnt_d = '0;
        end
        OUTPUT: begin
          if (mode) begin
            if (ks.key_ready) begin
              last_d = key_q;
              state_d = ADVANCE;
            end
          end else if (sw_is_key) begin
            cnt_d = '0;
          end else if (DEBOUNCE_CYCLES <= 1) begin
            state_d = UPDATE;
            key_d = KEY_WIDTH'(SW);
            cnt_d = '0;
          end else begin
            state_d = SETTLE;
            sample_d = SW;
            cnt_d = CW'(1);
          end
        end
        SETTLE: begin
          if (sw_is_key) begin
            state_d = OUTPUT;
            cnt_d = '0;
          end else if (SW != sample_q) begin
            sample_d = SW;
            cnt_d = CW'(1);
          end else if (cnt_q + CW'(1) >= DB_W) begin
            state_d = UPDATE;
            key_d = KEY_WIDTH'(sample_q);
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ADVANCE: begin
          if (next_w[KEY_WIDTH] || next_w > END_W) begin
            state_d = DONE;
            sdone_d = 1'b1;
          end else begin
            state_d = UPDATE;
            key_d = next_w[KEY_WIDTH-1:0];
          end
        end
        default: state_d = state_q;
      endcase
    end
    chg_d = state_d == UPDATE;
    avail_d = state_d == OUTPUT;
    led_d = state_d == FOUND ? fkey_d[LED_WIDTH-1:0] : state_d == DONE ? '1 : key_d[LED_WIDTH-1:0];
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      key_q <= '0;
      last_q <= '0;
      fkey_q <= '0;
      sample_q <= '0;
      cnt_q <= '0;
      led_q <= '0;
      kfound_q <= 1'b0;
      sdone_q <= 1'b0;
      chg_q <= 1'b0;
      avail_q <= 1'b0;
      mode_prev_q <= mode;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      last_q <= last_d;
      fkey_q <= fkey_d;
      sample_q <= sample_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
      kfound_q <= kfound_d;
      sdone_q <= sdone_d;
      chg_q <= chg_d;
      avail_q <= avail_d;
      mode_prev_q <= mode;
    end
  end
  assign ks.secret_key = key_q;
  assign ks.key_available = avail_q;
  assign ks.key_changed = chg_q;
  assign LEDR = led_q;
  assign key_found = kfound_q;
  assign found_key = fkey_q;
  assign sweep_done = sdone_q;
endmodule

// File: tb/tb_key_source_fsm.sv
// tb_key_source_fsm: scenario tasks with randomized stimulus against a keyspace/debounce reference
module tb_key_source_fsm;
  localparam int KW = 24, SWW = 10, LW = 10, DB = 4, KS = 0, KST = 2, KE = 6;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0;
  logic [SWW-1:0] sw = '0, cur;
  logic [LW-1:0] ledr;
  logic key_found, sweep_done;
  logic [KW-1:0] found_key;
  int checks = 0, errors = 0;
  int exp_keys[$];
  key_source_if #(.KEY_WIDTH(KW)) ks();
  key_source_fsm #(.KEY_WIDTH(KW), .SW_WIDTH(SWW), .LED_WIDTH(LW), .DEBOUNCE_CYCLES(DB),
    .KEY_START(KS), .KEY_STEP(KST), .KEY_END(KE)) dut (
    .CLOCK_50(clk), .reset(rst), .mode(mode), .SW(sw), .ks(ks), .LEDR(ledr),
    .key_found(key_found), .found_key(found_key), .sweep_done(sweep_done));
  always #5 clk = ~clk;
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic do_reset(input logic m, input logic [SWW-1:0] s);
    mode = m; sw = s; ks.key_ready = 1'b0; ks.found = 1'b0; rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    mode = 1'b0; sw = 10'h2A5; ks.key_ready = 1'b0; ks.found = 1'b0; rst = 1'b1;
    cyc(); cyc();
    checks++;
    if ({ks.secret_key, ks.key_available, ks.key_changed, key_found, found_key, sweep_done, ledr} !== '0) begin
      errors++;
      $display("FAIL reset_zero key=%h avail=%b chg=%b kf=%b fk=%h sd=%b led=%h required all 0",
        ks.secret_key, ks.key_available, ks.key_changed, key_found, found_key, sweep_done, ledr);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (ks.key_changed !== 1'b1 || ks.key_available !== 1'b0 || ks.secret_key !== 24'h0002A5) begin
      errors++;
      $display("FAIL first_update chg=%b avail=%b key=%h required 1 0 0002a5", ks.key_changed, ks.key_available, ks.secret_key);
    end
    cyc();
    checks++;
    if (ks.key_available !== 1'b1 || ks.key_changed !== 1'b0 || ledr !== 10'h2A5) begin
      errors++;
      $display("FAIL first_valid avail=%b chg=%b led=%h required 1 0 2a5", ks.key_available, ks.key_changed, ledr);
    end
  endtask
  task automatic test_debounce();
    int pulses = 0, at = 0;
    sw = 10'h2A6;
    repeat (2) begin cyc(); pulses += int'(ks.key_changed); end
    sw = 10'h2A5;
    repeat (3) begin cyc(); pulses += int'(ks.key_changed); end
    checks++;
    if (pulses != 0 || ks.secret_key !== 24'h0002A5 || ks.key_available !== 1'b1) begin
      errors++;
      $display("FAIL glitch_reject pulses=%0d key=%h avail=%b required 0 0002a5 1", pulses, ks.secret_key, ks.key_available);
    end
    sw = 10'h2A6;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (ks.key_changed) begin pulses++; at = i; end
    end
    checks++;
    if (pulses != 1 || at != DB || ks.secret_key !== 24'h0002A6 || ks.key_available !== 1'b1) begin
      errors++;
      $display("FAIL debounce_accept pulses=%0d at=%0d key=%h avail=%b required 1 %0d 0002a6 1", pulses, at, ks.secret_key, ks.key_available, DB);
    end
    cur = 10'h2A6;
  endtask
  task automatic test_manual_random();
    logic [SWW-1:0] v, e;
    int len, pulses;
    repeat (8) begin
      do v = 10'($urandom()); while (v == cur);
      len = $urandom_range(1, DB + 2);
      pulses = 0;
      sw = v;
      repeat (len) begin cyc(); pulses += int'(ks.key_changed); end
      if (len < DB) sw = cur;
      repeat (DB + 3) begin cyc(); pulses += int'(ks.key_changed); end
      e = len >= DB ? v : cur;
      checks++;
      if (ks.secret_key !== KW'(e) || pulses != int'(len >= DB) || ks.key_available !== 1'b1) begin
        errors++;
        $display("FAIL manual_random len=%0d key=%h pulses=%0d avail=%b required %h %0d 1", len, ks.secret_key, pulses, ks.key_available, e, int'(len >= DB));
      end
      cur = e;
    end
  endtask
  task automatic test_manual_found();
    ks.found = 1'b1;
    cyc();
    ks.found = 1'b0;
    checks++;
    if (key_found !== 1'b1 || found_key !== KW'(cur) || ledr !== cur || ks.key_available !== 1'b0) begin
      errors++;
      $display("FAIL manual_found kf=%b fk=%h led=%h avail=%b required 1 %h %h 0", key_found, found_key, ledr, ks.key_available, cur, cur);
    end
    sw = ~cur;
    repeat (DB + 3) cyc();
    checks++;
    if (key_found !== 1'b1 || found_key !== KW'(cur) || ks.key_available !== 1'b0 || ks.key_changed !== 1'b0) begin
      errors++;
      $display("FAIL manual_found_sticky kf=%b fk=%h avail=%b chg=%b required 1 %h 0 0", key_found, found_key, ks.key_available, ks.key_changed, cur);
    end
  endtask
  task automatic test_reset_mid_settle();
    do_reset(1'b0, 10'h155);
    cyc(); cyc();
    sw = 10'h0AA;
    cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if ({ks.secret_key, ks.key_available, ks.key_changed, key_found, found_key, sweep_done, ledr} !== '0) begin
      errors++;
      $display("FAIL reset_mid_settle key=%h avail=%b chg=%b led=%h required all 0", ks.secret_key, ks.key_available, ks.key_changed, ledr);
    end
    rst = 1'b0;
  endtask
  task automatic test_sweep();
    int got[$];
    int bad = 0, last_av = -1;
    do_reset(1'b1, '0);
    ks.key_ready = 1'b1;
    for (int i = 0; i < 80 && !sweep_done; i++) begin
      cyc();
      if (ks.key_changed) got.push_back(int'(ks.secret_key));
      if (ks.key_changed && ks.key_available) bad++;
      if (ks.key_available) begin
        if (last_av >= 0 && i - last_av != 3) bad++;
        last_av = i;
      end
    end
    checks++;
    if (got != exp_keys || bad != 0) begin
      errors++;
      $display("FAIL sweep_keys got=%p bad=%0d required %p 0", got, bad, exp_keys);
    end
    cyc();
    checks++;
    if (sweep_done !== 1'b1 || ks.key_available !== 1'b0 || ledr !== 10'h3FF) begin
      errors++;
      $display("FAIL sweep_done sd=%b avail=%b led=%h required 1 0 3ff", sweep_done, ks.key_available, ledr);
    end
  endtask
  task automatic test_backpressure();
    int n = 0, bad = 0;
    do_reset(1'b1, '0);
    ks.key_ready = 1'b1;
    while (!(ks.key_available && ks.secret_key == 4) && n < 40) begin cyc(); n++; end
    ks.key_ready = 1'b0;
    checks++;
    if (!(ks.key_available && ks.secret_key == 4)) begin
      errors++;
      $display("FAIL bp_reach_key4 key=%h avail=%b required 000004 1", ks.secret_key, ks.key_available);
    end
    repeat (10) begin
      cyc();
      if (ks.secret_key !== 24'd4 || ks.key_available !== 1'b1 || ks.key_changed !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold bad_cycles=%0d required 0", bad);
    end
    ks.key_ready = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!ks.key_changed && n < 20);
    checks++;
    if (ks.key_changed !== 1'b1 || ks.secret_key !== 24'd6 || n != 2) begin
      errors++;
      $display("FAIL bp_resume chg=%b key=%h cycles=%0d required 1 000006 2", ks.key_changed, ks.secret_key, n);
    end
  endtask
  task automatic test_sweep_random();
    int acc[$];
    int pulses = 0, bad = 0;
    logic r;
    logic [KW-1:0] pk;
    logic pa;
    do_reset(1'b1, '0);
    for (int i = 0; i < 400 && !sweep_done; i++) begin
      r = $urandom_range(0, 2) == 0;
      ks.key_ready = r;
      pa = ks.key_available && !r;
      pk = ks.secret_key;
      if (ks.key_available && r) acc.push_back(int'(ks.secret_key));
      cyc();
      pulses += int'(ks.key_changed);
      if (pa && (ks.key_available !== 1'b1 || ks.secret_key !== pk)) bad++;
    end
    checks++;
    if (acc != exp_keys || pulses != exp_keys.size() || bad != 0 || sweep_done !== 1'b1) begin
      errors++;
      $display("FAIL sweep_random acc=%p pulses=%0d bad=%0d sd=%b required %p %0d 0 1", acc, pulses, bad, sweep_done, exp_keys, exp_keys.size());
    end
  endtask
  task automatic test_sweep_found();
    int n = 0;
    do_reset(1'b1, '0);
    ks.key_ready = 1'b1;
    while (!(ks.key_available && ks.secret_key == KW'(exp_keys[2])) && n < 40) begin cyc(); n++; end
    ks.found = 1'b1;
    cyc();
    ks.found = 1'b0;
    checks++;
    if (key_found !== 1'b1 || found_key !== KW'(exp_keys[1]) || ledr !== LW'(exp_keys[1]) || ks.key_available !== 1'b0 || sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL sweep_found kf=%b fk=%h led=%h avail=%b sd=%b required 1 %h %h 0 0", key_found, found_key, ledr, ks.key_available, sweep_done, exp_keys[1], exp_keys[1]);
    end
    repeat (6) cyc();
    checks++;
    if (key_found !== 1'b1 || found_key !== KW'(exp_keys[1]) || ks.key_available !== 1'b0 || ks.key_changed !== 1'b0) begin
      errors++;
      $display("FAIL sweep_found_terminal kf=%b fk=%h avail=%b chg=%b required 1 %h 0 0", key_found, found_key, ks.key_available, ks.key_changed, exp_keys[1]);
    end
    ks.key_ready = 1'b0;
  endtask
  task automatic test_done_found();
    int n = 0;
    do_reset(1'b1, '0);
    ks.key_ready = 1'b1;
    while (!sweep_done && n < 80) begin cyc(); n++; end
    ks.found = 1'b1;
    cyc();
    ks.found = 1'b0;
    checks++;
    if (key_found !== 1'b1 || sweep_done !== 1'b1 || found_key !== KW'(exp_keys[$]) || ledr !== LW'(exp_keys[$])) begin
      errors++;
      $display("FAIL done_found kf=%b sd=%b fk=%h led=%h required 1 1 %h %h", key_found, sweep_done, found_key, ledr, exp_keys[$], exp_keys[$]);
    end
  endtask
  task automatic test_mode_toggle();
    int n = 0;
    logic [SWW-1:0] v;
    do_reset(1'b1, '0);
    ks.key_ready = 1'b1;
    while (!(ks.key_available && ks.secret_key == KW'(exp_keys[1])) && n < 40) begin cyc(); n++; end
    v = 10'($urandom());
    mode = 1'b0;
    sw = v;
    cyc();
    checks++;
    if ({ks.secret_key, ks.key_available, ks.key_changed, key_found, found_key, sweep_done, ledr} !== '0) begin
      errors++;
      $display("FAIL toggle_idle key=%h avail=%b chg=%b led=%h required all 0", ks.secret_key, ks.key_available, ks.key_changed, ledr);
    end
    cyc();
    checks++;
    if (ks.key_changed !== 1'b1 || ks.secret_key !== KW'(v)) begin
      errors++;
      $display("FAIL toggle_update chg=%b key=%h required 1 %h", ks.key_changed, ks.secret_key, v);
    end
    cyc();
    checks++;
    if (ks.key_available !== 1'b1 || ledr !== v) begin
      errors++;
      $display("FAIL toggle_valid avail=%b led=%h required 1 %h", ks.key_available, ledr, v);
    end
    ks.key_ready = 1'b0;
  endtask
  initial begin
    ks.key_ready = 1'b0;
    ks.found = 1'b0;
    for (longint k = KS; k <= KE; k += KST) exp_keys.push_back(int'(k));
    test_reset();
    test_debounce();
    test_manual_random();
    test_manual_found();
    test_reset_mid_settle();
    test_sweep();
    test_backpressure();
    test_sweep_random();
    test_sweep_found();
    test_done_found();
    test_mode_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
